beep_scheduler: RTL and testbench
=================================

BEEP_SCHEDULER -- requirements
Module: beep_scheduler

Interface
REQ-001 Parameter ON_CYCLES, default 20, length of one beep in clock cycles (200 ms at 100 Hz clk), SHALL be >=1.
REQ-002 Parameter GAP_CYCLES, default 10, silent cycles after every beep including the last, SHALL be >=1.
REQ-003 Parameters ALARM_BEEPS 4, TIMER_BEEPS 2, KEY_BEEPS 1: beeps per pattern for each source, each SHALL be >=1.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 req_alarm  input  1  alarm request; its rising edge counts as one request, at any level duration.
REQ-007 req_timer  input  1  countdown-timer request, edge-detected.
REQ-008 req_key  input  1  key-click request, edge-detected.
REQ-009 stop  input  1  user silence; aborts everything.
REQ-010 buzzer  output  1  registered buzzer drive.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 grant  output  2  source being played: 0 none, 1 key, 2 timer, 3 alarm.
REQ-013 done  output  1  one-cycle pulse when a pattern completes normally.

Function
REQ-014 Each req_* SHALL be edge-detected against its registered previous sample; a 0->1 transition SHALL set that source's pending flag.
REQ-015 Pending flags SHALL saturate: repeated edges before service yield one pattern.
REQ-016 States SHALL be IDLE, ON, GAP, REST.
REQ-017 IDLE with any pending flag SHALL grant the highest priority source (alarm > timer > key), clear its flag, load its beep count, and enter ON; buzzer high from the next cycle.
REQ-018 Latency: req edge sampled at edge E0 -> pending at E0 -> ON entered and buzzer=1 after E1.
REQ-019 An edge from the source being granted in the same cycle SHALL set its pending flag again (new request).
REQ-020 ON SHALL last exactly ON_CYCLES cycles with buzzer=1, then enter GAP if beeps remain, else REST.
REQ-021 GAP and REST SHALL last exactly GAP_CYCLES cycles with buzzer=0; GAP returns to ON, REST returns to IDLE.
REQ-022 REST->IDLE SHALL assert done for one cycle and set grant to 0.
REQ-023 A pattern of N beeps SHALL occupy N*(ON_CYCLES+GAP_CYCLES) cycles with busy=1.
REQ-024 stop=1 SHALL, in the same edge, clear all pending flags, enter IDLE, and set buzzer, grant and busy to 0; no done pulse. Request edges in that cycle SHALL be discarded.
REQ-025 Cycle and beep counters SHALL be sized by $clog2 of their parameter and SHALL never wrap.
REQ-026 Pending requests from other sources SHALL be kept while a pattern plays and served in priority order afterwards.

Reset
REQ-027 rst SHALL set state IDLE, buzzer=0, busy=0, grant=0, done=0, all pending flags and counters 0, and edge-detect registers to 0.
REQ-028 rst SHALL override stop and all requests. A req held high through reset SHALL produce one request on the first cycle after release.

Configuration
REQ-029 Macro BEEP_SCHEDULER_PREEMPT_EN defined: an alarm pending while a timer or key pattern is in ON or GAP SHALL abort it. Buzzer goes 0 on the next edge and the state enters REST (no done pulse). The aborted source is not re-pended, and the alarm is granted from IDLE.
REQ-030 Macro undefined: no preemption; an alarm waits until the current pattern completes, including REST.

Verification
REQ-031 req_key 1-cycle pulse -> buzzer high 20 cycles starting 2 edges after sample, low 10, done pulse, grant=1 throughout, busy 30 cycles.
REQ-032 req_alarm pulse -> 4 x (20 high, 10 low), grant=3, busy 120 cycles, one done.
REQ-033 req_timer and req_key rise in the same cycle -> timer 2 beeps (60 cycles, grant=2), then key 1 beep (grant=1), two done pulses.
REQ-034 stop at cycle 5 of the alarm's second beep -> buzzer 0 next cycle, grant 0, no done; a pending timer request is dropped.
REQ-035 alarm rises at cycle 5 of a key beep -> with PREEMPT_EN: buzzer drops next cycle, 10-cycle REST, then alarm pattern. Without the macro: key completes 30 cycles, then alarm.
REQ-036 req_key held high 500 cycles, then rst mid-pattern -> exactly one pattern before reset; all outputs 0 after the reset edge.

Source files
------------

// File: rtl/beep_scheduler.sv
// Three-source buzzer pattern scheduler (alarm > timer > key).
// Optional alarm preemption: define BEEP_SCHEDULER_PREEMPT_EN.
module beep_scheduler #(
   parameter int ON_CYCLES   = 20,
   parameter int GAP_CYCLES  = 10,
   parameter int ALARM_BEEPS = 4,
   parameter int TIMER_BEEPS = 2,
   parameter int KEY_BEEPS   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_alarm,
   input  logic       req_timer,
   input  logic       req_key,
   input  logic       stop,
   output logic       buzzer,
   output logic       busy,
   output logic [1:0] grant,
   output logic       done
);

   localparam int MAXC =
      (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
   localparam int MAXB0 =
      (ALARM_BEEPS > TIMER_BEEPS) ? ALARM_BEEPS : TIMER_BEEPS;
   localparam int MAXB =
      (MAXB0 > KEY_BEEPS) ? MAXB0 : KEY_BEEPS;
   localparam int CW = $clog2(MAXC + 1);
   localparam int BW = $clog2(MAXB + 1);

   typedef enum logic [1:0] {
      IDLE,
      ON,
      GAP,
      REST
   } state_t;

   state_t        state;
   logic [CW-1:0] cyc;
   logic [BW-1:0] beeps;
   logic          aborted;

   logic alarm_q;
   logic timer_q;
   logic key_q;
   logic pend_alarm;
   logic pend_timer;
   logic pend_key;

   logic edge_alarm;
   logic edge_timer;
   logic edge_key;
   logic take_alarm;
   logic take_timer;
   logic take_key;
   logic on_last;
   logic gap_last;
   logic preempt;

   assign edge_alarm = req_alarm & ~alarm_q;
   assign edge_timer = req_timer & ~timer_q;
   assign edge_key   = req_key & ~key_q;

   assign take_alarm = (state == IDLE) & pend_alarm;
   assign take_timer = (state == IDLE) & ~pend_alarm & pend_timer;
   assign take_key   = (state == IDLE) & ~pend_alarm & ~pend_timer
                       & pend_key;

   assign on_last  = (cyc == CW'(ON_CYCLES - 1));
   assign gap_last = (cyc == CW'(GAP_CYCLES - 1));

`ifdef BEEP_SCHEDULER_PREEMPT_EN
   assign preempt = pend_alarm & (grant != 2'd3)
                    & ((state == ON) | (state == GAP));
`else
   assign preempt = 1'b0;
`endif

   // previous request samples for rising-edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         alarm_q <= 1'b0;
         timer_q <= 1'b0;
         key_q   <= 1'b0;
      end else begin
         alarm_q <= req_alarm;
         timer_q <= req_timer;
         key_q   <= req_key;
      end
   end

   // saturating pending flags; a grant clears, a new edge re-sets
   always_ff @(posedge clk) begin
      if (rst || stop) begin
         pend_alarm <= 1'b0;
         pend_timer <= 1'b0;
         pend_key   <= 1'b0;
      end else begin
         pend_alarm <= (pend_alarm & ~take_alarm) | edge_alarm;
         pend_timer <= (pend_timer & ~take_timer) | edge_timer;
         pend_key   <= (pend_key & ~take_key) | edge_key;
      end
   end

   // pattern sequencer with registered outputs
   always_ff @(posedge clk) begin
      if (rst || stop) begin
         state   <= IDLE;
         cyc     <= '0;
         beeps   <= '0;
         aborted <= 1'b0;
         buzzer  <= 1'b0;
         busy    <= 1'b0;
         grant   <= 2'd0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               cyc     <= '0;
               aborted <= 1'b0;
               unique case (1'b1)
                  take_alarm: begin
                     grant <= 2'd3;
                     beeps <= BW'(ALARM_BEEPS);
                  end
                  take_timer: begin
                     grant <= 2'd2;
                     beeps <= BW'(TIMER_BEEPS);
                  end
                  take_key: begin
                     grant <= 2'd1;
                     beeps <= BW'(KEY_BEEPS);
                  end
                  default: ;
               endcase
               if (take_alarm | take_timer | take_key) begin
                  state  <= ON;
                  buzzer <= 1'b1;
                  busy   <= 1'b1;
               end
            end
            ON: begin
               if (preempt) begin
                  state   <= REST;
                  buzzer  <= 1'b0;
                  cyc     <= '0;
                  aborted <= 1'b1;
               end else if (on_last) begin
                  buzzer <= 1'b0;
                  cyc    <= '0;
                  beeps  <= beeps - 1'b1;
                  state  <= (beeps == BW'(1)) ? REST : GAP;
               end else begin
                  cyc <= cyc + 1'b1;
               end
            end
            GAP: begin
               if (preempt) begin
                  state   <= REST;
                  cyc     <= '0;
                  aborted <= 1'b1;
               end else if (gap_last) begin
                  state  <= ON;
                  buzzer <= 1'b1;
                  cyc    <= '0;
               end else begin
                  cyc <= cyc + 1'b1;
               end
            end
            REST: begin
               if (gap_last) begin
                  state   <= IDLE;
                  cyc     <= '0;
                  busy    <= 1'b0;
                  grant   <= 2'd0;
                  done    <= ~aborted;
                  aborted <= 1'b0;
               end else begin
                  cyc <= cyc + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_beep_scheduler.sv
// Scoreboard bench for beep_scheduler: expected patterns are
// queued per scenario and matched against observed patterns.
module tb_beep_scheduler;

   localparam int ON  = 20;
   localparam int GAP = 10;

   typedef struct packed {
      logic [1:0]  grant;
      logic [7:0]  beeps;
      logic [15:0] on_cyc;
      logic [15:0] busy_cyc;
      logic [3:0]  dones;
      logic        grant_ok;
   } pat_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_alarm;
   logic       req_timer;
   logic       req_key;
   logic       stop;
   logic       buzzer;
   logic       busy;
   logic [1:0] grant;
   logic       done;

   int   checks = 0;
   int   errors = 0;
   pat_t exp_q[$];
   pat_t obs_q[$];

   beep_scheduler dut (
      .clk       (clk),
      .rst       (rst),
      .req_alarm (req_alarm),
      .req_timer (req_timer),
      .req_key   (req_key),
      .stop      (stop),
      .buzzer    (buzzer),
      .busy      (busy),
      .grant     (grant),
      .done      (done)
   );

   always #5 clk = ~clk;

   function automatic pat_t mk(input logic [1:0] g, input int b,
                               input int on, input int bz,
                               input int d);
      pat_t p;
      p.grant    = g;
      p.beeps    = 8'(b);
      p.on_cyc   = 16'(on);
      p.busy_cyc = 16'(bz);
      p.dones    = 4'(d);
      p.grant_ok = 1'b1;
      return p;
   endfunction

   // pattern monitor: one record per busy interval
   initial begin
      pat_t cur;
      bit   in_pat;
      logic buz_prev;
      cur      = '0;
      in_pat   = 1'b0;
      buz_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            in_pat   = 1'b0;
            buz_prev = 1'b0;
         end else begin
            if (busy === 1'b1) begin
               if (!in_pat) begin
                  in_pat       = 1'b1;
                  cur          = '0;
                  cur.grant    = grant;
                  cur.grant_ok = 1'b1;
               end
               cur.busy_cyc = cur.busy_cyc + 16'd1;
               if (grant !== cur.grant) cur.grant_ok = 1'b0;
               if (buzzer === 1'b1) begin
                  cur.on_cyc = cur.on_cyc + 16'd1;
                  if (buz_prev !== 1'b1) cur.beeps = cur.beeps + 8'd1;
               end
            end else if (in_pat) begin
               in_pat    = 1'b0;
               cur.dones = {3'b000, done};
               obs_q.push_back(cur);
            end
            buz_prev = buzzer;
         end
      end
   end

   task automatic wait_obs(input int n, input int budget, output bit ok);
      int i;
      i = 0;
      while (obs_q.size() < n && i < budget) begin
         @(negedge clk);
         i++;
      end
      ok = (obs_q.size() >= n);
      @(negedge clk);
   endtask

   task automatic wait_buzzer(input logic lvl, input int budget);
      for (int i = 0; i < budget && buzzer !== lvl; i++)
         @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({buzzer, busy, grant, done} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs got %b expected 00000",
                  {buzzer, busy, grant, done});
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({buzzer, busy, grant, done} !== 5'b0) begin
         errors++;
         $display("FAIL idle_after_reset got %b expected 00000",
                  {buzzer, busy, grant, done});
      end
   endtask

   task automatic test_key();
      pat_t e, o;
      bit   ok;
      req_key = 1'b1;
      @(negedge clk);
      req_key = 1'b0;
      checks++;
      if (buzzer !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL key_latency_e0 got buzzer=%b busy=%b expected 0 0",
                  buzzer, busy);
      end
      @(negedge clk);
      checks++;
      if (buzzer !== 1'b1 || grant !== 2'd1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL key_latency_e1 got b=%b g=%0d busy=%b expected 1 1 1",
                  buzzer, grant, busy);
      end
      exp_q.push_back(mk(2'd1, 1, ON, ON + GAP, 1));
      wait_obs(1, 200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL key_timeout got %0d patterns expected 1",
                  obs_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = '0;
         if (obs_q.size() > 0) o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL key_pattern got %p expected %p", o, e);
         end
      end
   endtask

   task automatic test_alarm();
      pat_t e, o;
      bit   ok;
      req_alarm = 1'b1;
      @(negedge clk);
      req_alarm = 1'b0;
      exp_q.push_back(mk(2'd3, 4, 4 * ON, 4 * (ON + GAP), 1));
      wait_obs(1, 400, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL alarm_timeout got %0d patterns expected 1",
                  obs_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = '0;
         if (obs_q.size() > 0) o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL alarm_pattern got %p expected %p", o, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      pat_t e, o;
      bit   ok;
      req_timer = 1'b1;
      req_key   = 1'b1;
      @(negedge clk);
      req_timer = 1'b0;
      req_key   = 1'b0;
      exp_q.push_back(mk(2'd2, 2, 2 * ON, 2 * (ON + GAP), 1));
      exp_q.push_back(mk(2'd1, 1, ON, ON + GAP, 1));
      wait_obs(2, 400, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL b2b_timeout got %0d patterns expected 2",
                  obs_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = '0;
         if (obs_q.size() > 0) o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL b2b_pattern got %p expected %p", o, e);
         end
      end
   endtask

   task automatic test_saturate();
      pat_t e, o;
      bit   ok;
      req_alarm = 1'b1;
      @(negedge clk);
      req_alarm = 1'b0;
      repeat (3) begin
         repeat (4) @(negedge clk);
         req_key = 1'b1;
         @(negedge clk);
         req_key = 1'b0;
      end
      exp_q.push_back(mk(2'd3, 4, 4 * ON, 4 * (ON + GAP), 1));
      exp_q.push_back(mk(2'd1, 1, ON, ON + GAP, 1));
      wait_obs(2, 500, ok);
      repeat (60) @(negedge clk);
      checks++;
      if (obs_q.size() != 2) begin
         errors++;
         $display("FAIL saturate_count got %0d patterns expected 2",
                  obs_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = '0;
         if (obs_q.size() > 0) o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL saturate_pattern got %p expected %p", o, e);
         end
      end
      obs_q.delete();
   endtask

   task automatic test_stop();
      pat_t e, o;
      req_alarm = 1'b1;
      @(negedge clk);
      req_alarm = 1'b0;
      wait_buzzer(1'b1, 10);
      req_timer = 1'b1;
      @(negedge clk);
      req_timer = 1'b0;
      wait_buzzer(1'b0, 40);
      wait_buzzer(1'b1, 40);
      repeat (5) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      checks++;
      if ({buzzer, busy, grant, done} !== 5'b0) begin
         errors++;
         $display("FAIL stop_outputs got %b expected 00000",
                  {buzzer, busy, grant, done});
      end
      exp_q.push_back(mk(2'd3, 2, ON + 6, ON + GAP + 6, 0));
      repeat (80) @(negedge clk);
      checks++;
      if (obs_q.size() != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL stop_drops_timer got %0d patterns busy=%b expected 1 0",
                  obs_q.size(), busy);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = '0;
         if (obs_q.size() > 0) o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL stop_pattern got %p expected %p", o, e);
         end
      end
      obs_q.delete();
   endtask

   task automatic test_alarm_during_key();
      pat_t e, o;
      bit   ok;
      req_key = 1'b1;
      @(negedge clk);
      req_key = 1'b0;
      wait_buzzer(1'b1, 10);
      repeat (5) @(negedge clk);
      req_alarm = 1'b1;
      @(negedge clk);
      req_alarm = 1'b0;
`ifdef BEEP_SCHEDULER_PREEMPT_EN
      @(negedge clk);
      checks++;
      if (buzzer !== 1'b0 || grant !== 2'd1) begin
         errors++;
         $display("FAIL preempt_drop got b=%b g=%0d expected 0 1",
                  buzzer, grant);
      end
      exp_q.push_back(mk(2'd1, 1, 7, 7 + GAP, 0));
`else
      exp_q.push_back(mk(2'd1, 1, ON, ON + GAP, 1));
`endif
      exp_q.push_back(mk(2'd3, 4, 4 * ON, 4 * (ON + GAP), 1));
      wait_obs(2, 500, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL overlap_timeout got %0d patterns expected 2",
                  obs_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = '0;
         if (obs_q.size() > 0) o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL overlap_pattern got %p expected %p", o, e);
         end
      end
      obs_q.delete();
   endtask

   task automatic test_key_held_reset();
      pat_t e, o;
      bit   ok;
      req_key = 1'b1;
      repeat (500) @(negedge clk);
      checks++;
      if (obs_q.size() != 1) begin
         errors++;
         $display("FAIL held_count got %0d patterns expected 1",
                  obs_q.size());
      end
      exp_q.push_back(mk(2'd1, 1, ON, ON + GAP, 1));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = '0;
         if (obs_q.size() > 0) o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL held_pattern got %p expected %p", o, e);
         end
      end
      obs_q.delete();
      req_alarm = 1'b1;
      @(negedge clk);
      req_alarm = 1'b0;
      repeat (40) @(negedge clk);
      rst  = 1'b1;
      stop = 1'b1;
      @(negedge clk);
      checks++;
      if ({buzzer, busy, grant, done} !== 5'b0) begin
         errors++;
         $display("FAIL midreset_outputs got %b expected 00000",
                  {buzzer, busy, grant, done});
      end
      repeat (2) @(negedge clk);
      stop = 1'b0;
      rst  = 1'b0;
      exp_q.push_back(mk(2'd1, 1, ON, ON + GAP, 1));
      wait_obs(1, 100, ok);
      req_key = 1'b0;
      repeat (60) @(negedge clk);
      checks++;
      if (obs_q.size() != 1) begin
         errors++;
         $display("FAIL release_count got %0d patterns expected 1",
                  obs_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = '0;
         if (obs_q.size() > 0) o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL release_pattern got %p expected %p", o, e);
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      req_alarm = 1'b0;
      req_timer = 1'b0;
      req_key   = 1'b0;
      stop      = 1'b0;
      @(negedge clk);
      test_reset();
      test_key();
      test_alarm();
      test_back_to_back();
      test_saturate();
      test_stop();
      test_alarm_during_key();
      test_key_held_reset();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
